// File: rtl/strobed_io_port.sv
// strobed_io_port: one WIDTH-bit 8255-style Mode 1 strobed I/O port with IBF/OBF#/INTR handshake.
// Define STROBED_PORT_SYNC_EN to pass StbN/AckN through two-flop synchronisers (else one sampling flop).
module strobed_io_port #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ControlEnable,
    input  logic             GroupControl,
    input  logic             IntE,
    input  logic             Rd,
    input  logic             Wr,
    input  logic [WIDTH-1:0] DataIn,
    output logic [WIDTH-1:0] DataOut,
    input  logic [WIDTH-1:0] PortIn,
    output logic [WIDTH-1:0] PortOut,
    output logic             PortOe,
    input  logic             StbN,
    input  logic             AckN,
    output logic             Ibf,
    output logic             ObfN,
    output logic             Intr,
    output logic             Overrun
);

`ifdef STROBED_PORT_SYNC_EN
    localparam int SYNC_DEPTH = 2;
`else
    localparam int SYNC_DEPTH = 1;
`endif

    logic [SYNC_DEPTH-1:0] stb_sync_q, stb_sync_d;
    logic [SYNC_DEPTH-1:0] ack_sync_q, ack_sync_d;
    logic                  stb_s, ack_s;
    logic                  stb_prev_q, stb_prev_d;
    logic                  ack_prev_q, ack_prev_d;
    logic                  gc_prev_q, gc_prev_d;
    logic [SYNC_DEPTH:0]   arm_q, arm_d;
    logic                  armed;
    logic                  stb_fall, stb_rise, ack_fall, ack_rise, gc_change;
    logic [WIDTH-1:0]      data_out_q, data_out_d;
    logic [WIDTH-1:0]      in_latch_q, in_latch_d;
    logic [WIDTH-1:0]      out_latch_q, out_latch_d;
    logic                  ibf_q, ibf_d;
    logic                  obf_n_q, obf_n_d;
    logic                  intr_q, intr_d;
    logic                  ovr_q, ovr_d;

`ifdef STROBED_PORT_SYNC_EN
    assign stb_sync_d = {stb_sync_q[0], StbN};
    assign ack_sync_d = {ack_sync_q[0], AckN};
    assign stb_s      = stb_sync_q[1];
    assign ack_s      = ack_sync_q[1];
`else
    assign stb_sync_d = StbN;
    assign ack_sync_d = AckN;
    assign stb_s      = stb_sync_q[0];
    assign ack_s      = ack_sync_q[0];
`endif

    // Edges are masked until the previous-value register holds a real sample, so a
    // strobe held low across reset release is not mistaken for a falling edge.
    assign arm_d     = {arm_q[SYNC_DEPTH-1:0], 1'b1};
    assign armed     = arm_q[SYNC_DEPTH];
    assign stb_fall  = armed &  stb_prev_q & ~stb_s;
    assign stb_rise  = armed & ~stb_prev_q &  stb_s;
    assign ack_fall  = armed &  ack_prev_q & ~ack_s;
    assign ack_rise  = armed & ~ack_prev_q &  ack_s;
    assign gc_change = GroupControl ^ gc_prev_q;

    always_comb begin
        stb_prev_d  = stb_s;
        ack_prev_d  = ack_s;
        gc_prev_d   = GroupControl;
        data_out_d  = data_out_q;
        in_latch_d  = in_latch_q;
        out_latch_d = out_latch_q;
        ibf_d       = ibf_q;
        obf_n_d     = obf_n_q;
        intr_d      = intr_q;
        ovr_d       = ovr_q;

        if (ControlEnable) begin
            if (gc_change) begin
                ibf_d   = 1'b0;
                intr_d  = 1'b0;
                ovr_d   = 1'b0;
                obf_n_d = 1'b1;
            end else if (GroupControl) begin
                // Read is applied first so a coincident strobe fall captures into an empty buffer.
                if (Rd) begin
                    data_out_d = in_latch_q;
                    ibf_d      = 1'b0;
                    intr_d     = 1'b0;
                    ovr_d      = 1'b0;
                end
                if (stb_fall) begin
                    if (!ibf_d) begin
                        in_latch_d = PortIn;
                        ibf_d      = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
                if (stb_rise && ibf_d && IntE) begin
                    intr_d = 1'b1;
                end
            end else begin
                if (Rd) begin
                    data_out_d = out_latch_q;
                end
                if (Wr) begin
                    out_latch_d = DataIn;
                    obf_n_d     = 1'b0;
                    intr_d      = 1'b0;
                end else if (ack_fall) begin
                    obf_n_d = 1'b1;
                end
                if (ack_rise && obf_n_d && IntE) begin
                    intr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stb_sync_q  <= '1;
            ack_sync_q  <= '1;
            stb_prev_q  <= 1'b1;
            ack_prev_q  <= 1'b1;
            gc_prev_q   <= 1'b0;
            arm_q       <= '0;
            data_out_q  <= '0;
            in_latch_q  <= '0;
            out_latch_q <= '0;
            ibf_q       <= 1'b0;
            obf_n_q     <= 1'b1;
            intr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            stb_sync_q  <= stb_sync_d;
            ack_sync_q  <= ack_sync_d;
            stb_prev_q  <= stb_prev_d;
            ack_prev_q  <= ack_prev_d;
            gc_prev_q   <= gc_prev_d;
            arm_q       <= arm_d;
            data_out_q  <= data_out_d;
            in_latch_q  <= in_latch_d;
            out_latch_q <= out_latch_d;
            ibf_q       <= ibf_d;
            obf_n_q     <= obf_n_d;
            intr_q      <= intr_d;
            ovr_q       <= ovr_d;
        end
    end

    assign DataOut = data_out_q;
    assign PortOut = out_latch_q;
    assign PortOe  = ControlEnable & ~GroupControl;
    assign Ibf     = ibf_q;
    assign ObfN    = obf_n_q;
    assign Intr    = intr_q;
    assign Overrun = ovr_q;

endmodule

// File: tb/tb_strobed_io_port.sv
// tb_strobed_io_port: directed checks of strobed_io_port handshake, readback and corner cases.
// Flag latency follows STROBED_PORT_SYNC_EN (k+2 with sync, k+1 without).
module tb_strobed_io_port;

    localparam int W = 8;
`ifdef STROBED_PORT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         Clk;
    logic         Reset;
    logic         ControlEnable;
    logic         GroupControl;
    logic         IntE;
    logic         Rd;
    logic         Wr;
    logic [W-1:0] DataIn;
    logic [W-1:0] DataOut;
    logic [W-1:0] PortIn;
    logic [W-1:0] PortOut;
    logic         PortOe;
    logic         StbN;
    logic         AckN;
    logic         Ibf;
    logic         ObfN;
    logic         Intr;
    logic         Overrun;

    int total = 0;
    int bad   = 0;

    strobed_io_port #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .ControlEnable(ControlEnable), .GroupControl(GroupControl),
        .IntE(IntE), .Rd(Rd), .Wr(Wr), .DataIn(DataIn), .DataOut(DataOut), .PortIn(PortIn),
        .PortOut(PortOut), .PortOe(PortOe), .StbN(StbN), .AckN(AckN), .Ibf(Ibf), .ObfN(ObfN),
        .Intr(Intr), .Overrun(Overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic strobe(input logic [W-1:0] d);
        PortIn = d;
        StbN   = 1'b0;
        repeat (LAT + 2) step();
        StbN   = 1'b1;
        repeat (LAT + 2) step();
    endtask

    task automatic ack_pulse();
        AckN = 1'b0;
        repeat (LAT + 2) step();
        AckN = 1'b1;
        repeat (LAT + 2) step();
    endtask

    task automatic read_pulse();
        Rd = 1'b1;
        step();
        Rd = 1'b0;
    endtask

    task automatic write_pulse(input logic [W-1:0] d);
        DataIn = d;
        Wr     = 1'b1;
        step();
        Wr     = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; ControlEnable = 1'b1; GroupControl = 1'b1; IntE = 1'b1;
        Rd = 1'b0; Wr = 1'b0; DataIn = '0; PortIn = '0; StbN = 1'b1; AckN = 1'b1;
        repeat (3) step();
        check_output("rst_dataout", DataOut, 0);
        check_output("rst_portout", PortOut, 0);
        check_output("rst_portoe",  PortOe, 0);
        check_output("rst_ibf",     Ibf, 0);
        check_output("rst_obfn",    ObfN, 1);
        check_output("rst_intr",    Intr, 0);
        check_output("rst_overrun", Overrun, 0);
        Reset = 1'b0;
        repeat (3) step();

        // input mode strobe, interrupt on rising edge, read clears
        PortIn = 8'hA5;
        StbN   = 1'b0;
        step();
        check_output("in_ibf_at_k", Ibf, 0);
        repeat (LAT) step();
        check_output("in_ibf_lat", Ibf, 1);
        check_output("in_intr_on_fall", Intr, 0);
        repeat (3 - 1 - LAT) step();
        StbN = 1'b1;
        step();
        repeat (LAT) step();
        check_output("in_intr_on_rise", Intr, 1);
        check_output("in_dataout_before_rd", DataOut, 0);
        read_pulse();
        check_output("in_rd_data", DataOut, 8'hA5);
        check_output("in_rd_ibf", Ibf, 0);
        check_output("in_rd_intr", Intr, 0);

        // overrun
        strobe(8'hA5);
        strobe(8'h3C);
        check_output("ovr_set", Overrun, 1);
        check_output("ovr_ibf", Ibf, 1);
        read_pulse();
        check_output("ovr_latch_kept", DataOut, 8'hA5);
        check_output("ovr_cleared", Overrun, 0);
        check_output("ovr_ibf_cleared", Ibf, 0);

        // Rd coincident with strobe fall while full
        strobe(8'h11);
        PortIn = 8'h77;
        StbN   = 1'b0;
        repeat (LAT) step();
        Rd = 1'b1;
        step();
        Rd = 1'b0;
        check_output("coinc_rd_data", DataOut, 8'h11);
        check_output("coinc_ibf", Ibf, 1);
        check_output("coinc_overrun", Overrun, 0);
        check_output("coinc_intr", Intr, 0);
        StbN = 1'b1;
        repeat (LAT + 2) step();
        check_output("coinc_intr_rise", Intr, 1);
        read_pulse();
        check_output("coinc_new_data", DataOut, 8'h77);

        // IntE gating
        IntE = 1'b0;
        strobe(8'h22);
        check_output("inte0_ibf", Ibf, 1);
        check_output("inte0_intr", Intr, 0);
        read_pulse();
        IntE = 1'b1;
        strobe(8'h33);
        IntE = 1'b0;
        step();
        check_output("inte_drop_keeps_intr", Intr, 1);
        read_pulse();
        IntE = 1'b1;

        // output mode
        GroupControl = 1'b0;
        step();
        check_output("out_portoe", PortOe, 1);
        check_output("out_obfn_idle", ObfN, 1);
        write_pulse(8'h5A);
        check_output("out_portout", PortOut, 8'h5A);
        check_output("out_obfn_wr", ObfN, 0);
        AckN = 1'b0;
        step();
        check_output("out_obfn_at_k", ObfN, 0);
        repeat (LAT) step();
        check_output("out_obfn_ack", ObfN, 1);
        check_output("out_intr_on_fall", Intr, 0);
        step();
        AckN = 1'b1;
        step();
        repeat (LAT) step();
        check_output("out_intr_on_rise", Intr, 1);
        read_pulse();
        check_output("out_readback", DataOut, 8'h5A);
        check_output("out_rd_no_effect", ObfN, 1);
        write_pulse(8'hC3);
        check_output("out_wr_clr_intr", Intr, 0);
        check_output("out_wr2_obfn", ObfN, 0);
        write_pulse(8'hD4);
        check_output("out_overwrite", PortOut, 8'hD4);
        check_output("out_overwrite_obfn", ObfN, 0);

        // Wr coincident with AckN fall
        ack_pulse();
        check_output("out_ack2_obfn", ObfN, 1);
        AckN = 1'b0;
        repeat (LAT) step();
        write_pulse(8'h99);
        check_output("coinc_wr_obfn", ObfN, 0);
        check_output("coinc_wr_portout", PortOut, 8'h99);
        check_output("coinc_wr_intr", Intr, 0);
        AckN = 1'b1;
        repeat (LAT + 2) step();
        check_output("coinc_wr_no_intr_rise", Intr, 0);

        // direction change clears handshake
        GroupControl = 1'b1;
        step();
        check_output("gc_obfn", ObfN, 1);
        check_output("gc_portoe", PortOe, 0);
        check_output("gc_intr", Intr, 0);
        check_output("gc_latch_kept", PortOut, 8'h99);

        // ControlEnable low
        GroupControl = 1'b0;
        step();
        ControlEnable = 1'b0;
        step();
        check_output("ce0_portoe", PortOe, 0);
        write_pulse(8'h44);
        check_output("ce0_wr_ignored", PortOut, 8'h99);
        check_output("ce0_obfn", ObfN, 1);
        ControlEnable = 1'b1;
        step();
        check_output("ce1_portoe", PortOe, 1);

        // reset mid-handshake, StbN held low through release
        GroupControl = 1'b1;
        step();
        strobe(8'hAB);
        check_output("pre_rst_ibf", Ibf, 1);
        check_output("pre_rst_intr", Intr, 1);
        PortIn = 8'hCD;
        StbN   = 1'b0;
        step();
        Reset = 1'b1;
        #2;
        check_output("mid_rst_ibf", Ibf, 0);
        check_output("mid_rst_intr", Intr, 0);
        check_output("mid_rst_obfn", ObfN, 1);
        check_output("mid_rst_dataout", DataOut, 0);
        check_output("mid_rst_portout", PortOut, 0);
        check_output("mid_rst_overrun", Overrun, 0);
        step();
        Reset = 1'b0;
        repeat (LAT + 3) step();
        check_output("post_rst_no_edge", Ibf, 0);
        StbN = 1'b1;
        repeat (LAT + 2) step();
        check_output("post_rst_ibf", Ibf, 0);
        check_output("post_rst_intr", Intr, 0);
        strobe(8'h5C);
        check_output("post_rst_strobe", Ibf, 1);
        read_pulse();
        check_output("post_rst_data", DataOut, 8'h5C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
